apb_ram_param: RTL and testbench



---
 rtl/apb_ram_param.sv | 241 ++++++++++++++++++++++++
 tb/tb_apb_ram_param.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_ram_param.sv
// -----------------------------------------------------------------------------
// apb_ram_param
//   Parametrised APB slave RAM. Word-organised storage of DEPTH words of
//   DATA_W bits, addressed by byte address on paddr. Transfers may be
//   stretched by WAIT_CYCLES wait states. Misaligned or out-of-range accesses
//   return an error and leave memory untouched. A master that drops psel
//   mid-transfer aborts it.
//
// Parameters
//   DATA_W       data bus width (multiple of 8, >= 8)
//   ADDR_W       paddr width
//   DEPTH        number of DATA_W words
//   WAIT_CYCLES  wait states before pready (0..255)
//
// Ports
//   pclk     in   clock, rising edge
//   preset   in   synchronous active-high reset
//   psel     in   slave select
//   penable  in   access-phase strobe
//   pwrite   in   1 = write, 0 = read
//   paddr    in   byte address [ADDR_W]
//   pwdata   in   write data [DATA_W]
//   pstrb    in   byte-lane write strobes [DATA_W/8] (APB_RAM_PSTRB_EN only)
//   prdata   out  read data, valid while pready=1 on a read
//   pready   out  transfer complete
//   pslverr  out  error response, valid while pready=1
//
// Configuration macro
//   APB_RAM_PSTRB_EN : adds the pstrb port; writes update only strobed lanes.
//                      Without it every write updates the full word.
// -----------------------------------------------------------------------------
module apb_ram_param #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
`ifdef APB_RAM_PSTRB_EN
  input  logic [DATA_W/8-1:0] pstrb,
`endif
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int NB    = DATA_W / 8;
  localparam int AL    = $clog2(NB);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Low address bits that must be zero for a word-aligned access.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << AL) - 64'd1);
  localparam logic [ADDR_W-1:0] DEPTH_A    = ADDR_W'(DEPTH);
  localparam logic [7:0]        WAIT_INIT  = 8'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [7:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
`ifdef APB_RAM_PSTRB_EN
  logic [NB-1:0]     strb_q;
`endif

  logic [DATA_W-1:0] mem [DEPTH];

  // Control decoded by the next-state logic.
  logic latch;
  logic dec;
  logic complete;
  logic clear;

  // Effective transfer attributes: with zero wait states completion happens
  // on the setup edge itself, before anything has been latched, so the live
  // bus is used in IDLE and the latched copy everywhere else.
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_write;
  logic [DATA_W-1:0] sel_wdata;
  logic [NB-1:0]     sel_strb;
  logic [ADDR_W-1:0] idx_full;
  logic [IDX_W-1:0]  idx;
  logic              err;

  // Select live or latched transfer attributes and decode errors.
  always_comb begin
    sel_addr  = addr_q;
    sel_write = write_q;
    sel_wdata = wdata_q;
    sel_strb  = {NB{1'b1}};
    if (state == ST_IDLE) begin
      sel_addr  = paddr;
      sel_write = pwrite;
      sel_wdata = pwdata;
`ifdef APB_RAM_PSTRB_EN
      sel_strb  = pstrb;
`endif
    end else begin
`ifdef APB_RAM_PSTRB_EN
      sel_strb  = strb_q;
`endif
    end
    idx_full = sel_addr >> AL;
    idx      = idx_full[IDX_W-1:0];
    err      = (|(sel_addr & ALIGN_MASK)) || (idx_full >= DEPTH_A);
  end

  // Next-state and control decode.
  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    dec       = 1'b0;
    complete  = 1'b0;
    clear     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (psel && !penable) begin
          latch = 1'b1;
          if (WAIT_CYCLES == 0) begin
            complete  = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_WAIT;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!psel) begin
          // Master abort: nothing committed, pready never raised.
          state_nxt = ST_IDLE;
        end else if (penable) begin
          dec = 1'b1;
          if (cnt == 8'd1) begin
            complete  = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_WAIT;
          end
        end else begin
          // Setup phase re-presented mid-transfer: hold without counting.
          state_nxt = ST_WAIT;
        end
      end
      ST_DONE: begin
        // Completion sampled or master gone: either way the response ends.
        clear     = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        clear     = 1'b1;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Transfer capture and wait-state counter.
  always_ff @(posedge pclk) begin
    if (preset) begin
      cnt     <= 8'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
`ifdef APB_RAM_PSTRB_EN
      strb_q  <= '0;
`endif
    end else if (latch) begin
      cnt     <= WAIT_INIT;
      addr_q  <= paddr;
      write_q <= pwrite;
      wdata_q <= pwdata;
`ifdef APB_RAM_PSTRB_EN
      strb_q  <= pstrb;
`endif
    end else if (dec) begin
      cnt <= cnt - 8'd1;
    end else begin
      cnt <= cnt;
    end
  end

  // Registered response outputs.
  always_ff @(posedge pclk) begin
    if (preset) begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else if (complete) begin
      pready  <= 1'b1;
      pslverr <= err;
      prdata  <= (err || sel_write) ? '0 : mem[idx];
    end else if (clear) begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      pready  <= pready;
      pslverr <= pslverr;
      prdata  <= prdata;
    end
  end

  // Storage array; writes commit only on an error-free completion.
  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (complete && !err && sel_write) begin
      for (int i = 0; i < NB; i++) begin
        if (sel_strb[i]) begin
          mem[idx][8*i +: 8] <= sel_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_ram_param.sv
`timescale 1ns/1ps
module tb_apb_ram_param;

  // Three instances share the bus; each has its own psel and wait count.
  logic        clk;
  logic        preset;
  logic [2:0]  psel_v;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
`ifdef APB_RAM_PSTRB_EN
  logic [3:0]  pstrb;
`endif
  logic [31:0] rd0, rd1, rd2;
  logic        rdy0, rdy1, rdy2;
  logic        err0, err1, err2;

  logic        exp_rdy [3];
  logic        exp_err [3];
  logic [31:0] exp_rd  [3];
  logic [31:0] mdl [3][32];
  logic        chk_on;
  int          pass_cnt;
  int          tot_cnt;

  apb_ram_param #(.DATA_W(32), .ADDR_W(32), .DEPTH(32), .WAIT_CYCLES(0)) u_d0 (
    .pclk(clk), .preset(preset), .psel(psel_v[0]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
`ifdef APB_RAM_PSTRB_EN
    .pstrb(pstrb),
`endif
    .prdata(rd0), .pready(rdy0), .pslverr(err0));

  apb_ram_param #(.DATA_W(32), .ADDR_W(32), .DEPTH(32), .WAIT_CYCLES(3)) u_d1 (
    .pclk(clk), .preset(preset), .psel(psel_v[1]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
`ifdef APB_RAM_PSTRB_EN
    .pstrb(pstrb),
`endif
    .prdata(rd1), .pready(rdy1), .pslverr(err1));

  apb_ram_param #(.DATA_W(32), .ADDR_W(32), .DEPTH(32), .WAIT_CYCLES(2)) u_d2 (
    .pclk(clk), .preset(preset), .psel(psel_v[2]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
`ifdef APB_RAM_PSTRB_EN
    .pstrb(pstrb),
`endif
    .prdata(rd2), .pready(rdy2), .pslverr(err2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wait_of(input int d);
    case (d)
      0:       return 0;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [31:0] rd_of(input int d);
    case (d)
      0:       return rd0;
      1:       return rd1;
      default: return rd2;
    endcase
  endfunction

  function automatic logic rdy_of(input int d);
    case (d)
      0:       return rdy0;
      1:       return rdy1;
      default: return rdy2;
    endcase
  endfunction

  function automatic logic err_of(input int d);
    case (d)
      0:       return err0;
      1:       return err1;
      default: return err2;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tot_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
  endtask

  // Every cycle: all three slaves against the expected response.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("d0_pready",  {31'd0, rdy0}, {31'd0, exp_rdy[0]});
      chk("d0_pslverr", {31'd0, err0}, {31'd0, exp_err[0]});
      chk("d0_prdata",  rd0, exp_rd[0]);
      chk("d1_pready",  {31'd0, rdy1}, {31'd0, exp_rdy[1]});
      chk("d1_pslverr", {31'd0, err1}, {31'd0, exp_err[1]});
      chk("d1_prdata",  rd1, exp_rd[1]);
      chk("d2_pready",  {31'd0, rdy2}, {31'd0, exp_rdy[2]});
      chk("d2_pslverr", {31'd0, err2}, {31'd0, exp_err[2]});
      chk("d2_prdata",  rd2, exp_rd[2]);
    end
  end

  // Advance one cycle; expected outputs default to the quiet response.
  task automatic cyc();
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      exp_rdy[d] = 1'b0;
      exp_err[d] = 1'b0;
      exp_rd[d]  = 32'd0;
    end
  endtask

  task automatic idle();
    cyc();
    psel_v  = 3'b000;
    penable = 1'b0;
  endtask

  task automatic clear_model();
    for (int d = 0; d < 3; d++)
      for (int w = 0; w < 32; w++)
        mdl[d][w] = 32'd0;
  endtask

  // One APB transfer on slave d. abort_at / reset_at name the access cycle
  // (1-based) in which psel is dropped / preset raised; 0 means never.
  task automatic xfer(input int d, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] st,
                      input int abort_at, input int reset_at,
                      output logic [31:0] got_rd, output logic got_err,
                      output int lat);
    int          w;
    logic        e;
    logic [31:0] word;
    w      = wait_of(d);
    e      = (a[1:0] != 2'd0) || ((a >> 2) >= 32'd32);
    lat    = 0;
    got_rd = 32'd0;
    got_err = 1'b0;
    cyc();
    psel_v    = 3'b000;
    psel_v[d] = 1'b1;
    penable   = 1'b0;
    pwrite    = wr;
    paddr     = a;
    pwdata    = wd;
`ifdef APB_RAM_PSTRB_EN
    pstrb     = st;
`endif
    for (int k = 1; k <= w + 1; k++) begin
      cyc();
      if (k == w + 1) begin
        exp_rdy[d] = 1'b1;
        exp_err[d] = e;
        exp_rd[d]  = (e || wr) ? 32'd0 : mdl[d][a >> 2];
        if (!e && wr) begin
          word = mdl[d][a >> 2];
          for (int i = 0; i < 4; i++) begin
`ifdef APB_RAM_PSTRB_EN
            if (st[i]) word[8*i +: 8] = wd[8*i +: 8];
`else
            word[8*i +: 8] = wd[8*i +: 8];
`endif
          end
          mdl[d][a >> 2] = word;
        end
      end
      if (rdy_of(d) && lat == 0) begin
        lat     = k;
        got_rd  = rd_of(d);
        got_err = err_of(d);
      end
      // Bus noise during the access phase must be ignored by the slave.
      penable = 1'b1;
      pwrite  = ~wr;
      paddr   = ~a;
      pwdata  = ~wd;
`ifdef APB_RAM_PSTRB_EN
      pstrb   = ~st;
`endif
      if (k == abort_at) begin
        psel_v  = 3'b000;
        penable = 1'b0;
        break;
      end
      if (k == reset_at) begin
        preset = 1'b1;
        break;
      end
    end
    if (reset_at != 0) begin
      cyc();
      preset  = 1'b0;
      psel_v  = 3'b000;
      penable = 1'b0;
      clear_model();
    end
  endtask

  logic [31:0] r;
  logic        e;
  int          l;

  initial begin
    chk_on   = 1'b0;
    pass_cnt = 0;
    tot_cnt  = 0;
    preset   = 1'b1;
    psel_v   = 3'b000;
    penable  = 1'b0;
    pwrite   = 1'b0;
    paddr    = 32'd0;
    pwdata   = 32'd0;
`ifdef APB_RAM_PSTRB_EN
    pstrb    = 4'h0;
`endif
    clear_model();
    for (int d = 0; d < 3; d++) begin
      exp_rdy[d] = 1'b0;
      exp_err[d] = 1'b0;
      exp_rd[d]  = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    preset = 1'b0;
    chk_on = 1'b1;
    idle();
    chk("rst_pready", {31'd0, rdy0}, 32'd0);

    // 1: zero wait states, write then read.
    xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 0, 0, r, e, l);
    chk("t1_wr_lat", 32'(l), 32'd1);
    chk("t1_wr_err", {31'd0, e}, 32'd0);
    xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 0, 0, r, e, l);
    chk("t1_rd_data", r, 32'hDEADBEEF);
    chk("t1_rd_lat", 32'(l), 32'd1);
    idle();

    // 2: three wait states, read of a reset word.
    xfer(1, 1'b0, 32'h04, 32'h0, 4'h0, 0, 0, r, e, l);
    chk("t2_lat", 32'(l), 32'd4);
    chk("t2_data", r, 32'd0);
    idle();

    // 3: out-of-range and misaligned writes.
    xfer(0, 1'b1, 32'h80, 32'hCAFEF00D, 4'hF, 0, 0, r, e, l);
    chk("t3_oor_err", {31'd0, e}, 32'd1);
    xfer(0, 1'b1, 32'h06, 32'hCAFEF00D, 4'hF, 0, 0, r, e, l);
    chk("t3_mis_err", {31'd0, e}, 32'd1);
    xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, 0, 0, r, e, l);
    chk("t3_rd0", r, 32'd0);
    xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 0, 0, r, e, l);
    chk("t3_rd4", r, 32'd0);
    xfer(1, 1'b0, 32'h7E, 32'h0, 4'h0, 0, 0, r, e, l);
    chk("t3_d1_err", {31'd0, e}, 32'd1);
    idle();

    // 4: back-to-back, no idle cycles, on both wait settings.
    xfer(0, 1'b1, 32'h00, 32'h11, 4'hF, 0, 0, r, e, l);
    xfer(0, 1'b1, 32'h04, 32'h22, 4'hF, 0, 0, r, e, l);
    xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, 0, 0, r, e, l);
    chk("t4_rd0", r, 32'h11);
    xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 0, 0, r, e, l);
    chk("t4_rd4", r, 32'h22);
    xfer(1, 1'b1, 32'h7C, 32'h33, 4'hF, 0, 0, r, e, l);
    xfer(1, 1'b0, 32'h7C, 32'h0, 4'h0, 0, 0, r, e, l);
    chk("t4_d1_raw", r, 32'h33);
    idle();

    // 5: abort in first wait cycle, then abort after completion.
    xfer(2, 1'b1, 32'h0C, 32'h55, 4'hF, 1, 0, r, e, l);
    chk("t5_abort_lat", 32'(l), 32'd0);
    idle();
    xfer(2, 1'b0, 32'h0C, 32'h0, 4'h0, 0, 0, r, e, l);
    chk("t5_abort_rd", r, 32'd0);
    chk("t5_rd_lat", 32'(l), 32'd3);
    xfer(2, 1'b1, 32'h14, 32'h77, 4'hF, 3, 0, r, e, l);
    idle();
    xfer(2, 1'b0, 32'h14, 32'h0, 4'h0, 0, 0, r, e, l);
    chk("t5_done_abort_rd", r, 32'h77);

    // Reset while a read response is being presented.
    xfer(1, 1'b1, 32'h10, 32'h12345678, 4'hF, 0, 0, r, e, l);
    xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, 4, r, e, l);
    chk("t5_rst_rd", r, 32'h12345678);
    chk("t5_rst_rdy", {31'd0, rdy1}, 32'd0);
    xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 0, 0, r, e, l);
    chk("t5_mem_cleared", r, 32'd0);
    idle();

    // 6: byte-lane strobes (full-word overwrite when strobes are absent).
    xfer(0, 1'b1, 32'h10, 32'hAABBCCDD, 4'hF, 0, 0, r, e, l);
    xfer(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 0, 0, r, e, l);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 0, r, e, l);
`ifdef APB_RAM_PSTRB_EN
    chk("t6_strb", r, 32'hAA22CC44);
    xfer(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 0, 0, r, e, l);
    chk("t6_nostrb_err", {31'd0, e}, 32'd0);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 0, r, e, l);
    chk("t6_nostrb_rd", r, 32'hAA22CC44);
`else
    chk("t6_full", r, 32'h11223344);
`endif
    idle();
    idle();
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
